// File: rtl/fredkin_updown_counter.sv
// fredkin_updown_counter: up/down counter with parallel load whose T-flop toggles come only from Fredkin gates

// fredkin_gate: controlled swap; c=0 passes (a,b), c=1 swaps to (b,a); control output is the c wire itself
module fredkin_gate (
    input  logic c,
    input  logic a,
    input  logic b,
    output logic x,
    output logic y
);
    assign x = c ? b : a;
    assign y = c ? a : b;
endmodule

module fredkin_updown_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qb,
    output logic             tc
);
    logic [WIDTH-1:0] s, c, dn, tld, t;
    logic             tc_raw;

    assign qb   = ~q;
    assign c[0] = en;

    genvar i;
    generate
        for (i = 0; i < WIDTH; i++) begin : g_bit
            fredkin_gate u_dir (.c(up), .a(qb[i]), .b(q[i]), .x(s[i]), .y());
            fredkin_gate u_inv (.c(d[i]), .a(1'b1), .b(1'b0), .x(dn[i]), .y());
            fredkin_gate u_xor (.c(q[i]), .a(d[i]), .b(dn[i]), .x(tld[i]), .y());
            fredkin_gate u_sel (.c(load), .a(c[i]), .b(tld[i]), .x(t[i]), .y());
        end
        for (i = 1; i < WIDTH; i++) begin : g_carry
            fredkin_gate u_and (.c(c[i-1]), .a(s[i-1]), .b(1'b0), .x(), .y(c[i]));
        end
    endgenerate

    fredkin_gate u_tc_and  (.c(c[WIDTH-1]), .a(s[WIDTH-1]), .b(1'b0), .x(), .y(tc_raw));
    fredkin_gate u_tc_gate (.c(load), .a(tc_raw), .b(1'b0), .x(tc), .y());

    // T flip-flops: apply the toggle vector, reset clears
    always_ff @(posedge clk) begin
        if (rst) q <= '0;
        else     q <= q ^ t;
    end
endmodule

// File: tb/tb_fredkin_updown_counter.sv
// tb_fredkin_updown_counter: directed plus random checks of three counter widths against an arithmetic model
module tb_fredkin_updown_counter;
    logic       clk = 1'b0;
    logic       rst = 1'b0, en = 1'b0, up = 1'b0, load = 1'b0;
    logic [7:0] d = '0;
    logic [1:0] q2, qb2;
    logic [3:0] q4, qb4;
    logic [7:0] q8, qb8;
    logic       tc2, tc4, tc8;
    int         vectors = 0, miscompares = 0;
    int         m2 = 0, m4 = 0, m8 = 0;
    bit         armed = 1'b0;

    always #5 clk = ~clk;

    fredkin_updown_counter #(.WIDTH(2)) u_w2 (.clk(clk), .rst(rst), .en(en), .up(up), .load(load),
        .d(d[1:0]), .q(q2), .qb(qb2), .tc(tc2));
    fredkin_updown_counter #(.WIDTH(4)) u_w4 (.clk(clk), .rst(rst), .en(en), .up(up), .load(load),
        .d(d[3:0]), .q(q4), .qb(qb4), .tc(tc4));
    fredkin_updown_counter #(.WIDTH(8)) u_w8 (.clk(clk), .rst(rst), .en(en), .up(up), .load(load),
        .d(d), .q(q8), .qb(qb8), .tc(tc8));

    function automatic int nxt(int cur, int w, bit r, bit l, bit e, bit u, int dv);
        int mask = (1 << w) - 1;
        if (r) return 0;
        if (l) return dv & mask;
        if (e) return (cur + (u ? 1 : -1)) & mask;
        return cur;
    endfunction

    function automatic int tc_of(int cur, int w, bit l, bit e, bit u);
        return (e && !l && (u ? cur == (1 << w) - 1 : cur == 0)) ? 1 : 0;
    endfunction

    task automatic cmp(string name, int got, int exp);
        vectors++;
        if (got != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model advances on every edge from the sampled inputs
    always @(posedge clk) begin
        m2 <= nxt(m2, 2, rst, load, en, up, int'(d));
        m4 <= nxt(m4, 4, rst, load, en, up, int'(d));
        m8 <= nxt(m8, 8, rst, load, en, up, int'(d));
        if (rst) armed <= 1'b1;
    end

    // Compare all outputs of every width once the first reset has been taken
    always @(negedge clk) begin
        if (armed) begin
            cmp("q2", int'(q2), m2);
            cmp("qb2", int'(qb2), (~m2) & 3);
            cmp("tc2", int'(tc2), tc_of(m2, 2, load, en, up));
            cmp("q4", int'(q4), m4);
            cmp("qb4", int'(qb4), (~m4) & 15);
            cmp("tc4", int'(tc4), tc_of(m4, 4, load, en, up));
            cmp("q8", int'(q8), m8);
            cmp("qb8", int'(qb8), (~m8) & 255);
            cmp("tc8", int'(tc8), tc_of(m8, 8, load, en, up));
        end
    end

    task automatic step(bit r, bit e, bit u, bit l, logic [7:0] dv);
        rst = r; en = e; up = u; load = l; d = dv;
        @(posedge clk);
        #1;
    endtask

    initial begin
        step(1, 0, 0, 0, 8'h00);
        cmp("rst_q", int'(q4), 0);
        cmp("rst_qb", int'(qb4), 15);
        cmp("rst_tc", int'(tc4), 0);
        for (int k = 1; k <= 17; k++) begin
            step(0, 1, 1, 0, 8'h00);
            if (k == 15) begin
                cmp("up_q15", int'(q4), 15);
                cmp("up_tc15", int'(tc4), 1);
            end
            if (k == 16) begin
                cmp("up_wrap", int'(q4), 0);
                cmp("up_tc0", int'(tc4), 0);
            end
        end
        cmp("up_q17", int'(q4), 1);
        step(0, 0, 0, 1, 8'h02);
        cmp("ld2", int'(q4), 2);
        for (int k = 1; k <= 4; k++) begin
            step(0, 1, 0, 0, 8'h00);
            if (k == 2) begin
                cmp("dn_q0", int'(q4), 0);
                cmp("dn_tc0", int'(tc4), 1);
            end
            if (k == 3) begin
                cmp("dn_wrap", int'(q4), 15);
                cmp("dn_tc15", int'(tc4), 0);
            end
        end
        cmp("dn_q14", int'(q4), 14);
        step(0, 0, 0, 1, 8'h07);
        step(0, 1, 1, 1, 8'h0A);
        cmp("ld_pri", int'(q4), 10);
        cmp("ld_tc", int'(tc4), 0);
        step(0, 0, 0, 1, 8'h05);
        for (int k = 0; k < 3; k++) step(0, 0, 1, 0, 8'h00);
        cmp("hold", int'(q4), 5);
        step(0, 1, 1, 0, 8'h00);
        cmp("flip_6", int'(q4), 6);
        step(0, 1, 0, 0, 8'h00);
        cmp("flip_5", int'(q4), 5);
        step(0, 1, 1, 0, 8'h00);
        cmp("flip_6b", int'(q4), 6);
        step(0, 0, 0, 1, 8'h0C);
        step(0, 1, 1, 0, 8'h00);
        step(1, 1, 1, 1, 8'h03);
        cmp("rst_mid_q", int'(q4), 0);
        cmp("rst_mid_qb", int'(qb4), 15);
        step(0, 1, 1, 0, 8'h00);
        cmp("resume", int'(q4), 1);
        step(0, 1, 1, 1, 8'h01);
        cmp("ld_same", int'(q4), 1);
        for (int k = 0; k < 2000; k++)
            step($urandom_range(0, 99) == 0, 1'($urandom), 1'($urandom),
                 $urandom_range(0, 7) == 0, 8'($urandom));
        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
